array_27_rw_ctrl: RTL and testbench
===================================

# array_27_rw_ctrl

Request-side controller for the 512×210 single-port, 10-segment masked SRAM macro (RW0 port, 1-cycle registered read). It clears the array after reset, accepts masked write and read requests over a valid/ready interface, and drives the macro's RW0 port. Read data returns in order through a credit-limited response buffer, so upstream backpressure never loses SRAM output. It sits between the cache/predictor pipeline and the `array_27_ext` instance.

## Interface
- DEPTH, 512, number of SRAM entries
- ADDR_W, 9, address width
- DATA_W, 210, data width
- MASK_SEG, 10, write-mask segments (each segment is DATA_W/MASK_SEG = 21 bits)
- RESP_DEPTH, 3, response buffer entries
- CLEAR_ON_RESET, 1, if 1 the block zero-fills the array after reset
- clock  in  1  single clock; also drives the macro's RW0_clk
- reset  in  1  synchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_write  in  1  1 = masked write, 0 = read
- req_addr  in  ADDR_W  entry address
- req_wmask  in  MASK_SEG  per-segment write enable
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  read data valid
- resp_ready  in  1  consumer accepts response
- resp_data  out  DATA_W  read data, in request order
- init_done  out  1  clear sweep complete
- sram_en, sram_wmode  out  1 each  to RW0_en / RW0_wmode
- sram_addr  out  ADDR_W  to RW0_addr
- sram_wmask  out  MASK_SEG  to RW0_wmask
- sram_wdata  out  DATA_W  to RW0_wdata
- sram_rdata  in  DATA_W  from RW0_rdata

## Operation
- FSM states: INIT, RUN.
  - Reset forces INIT.
  - With CLEAR_ON_RESET=0, INIT lasts exactly one cycle.
- INIT: 9-bit counter 0..DEPTH-1 drives sram_en=1, sram_wmode=1, sram_wmask=all ones, sram_wdata=0, sram_addr=counter. One entry per cycle. After entry DEPTH-1: state→RUN, init_done=1.
- RUN: the SRAM port is driven combinationally from the request. sram_en = req_valid&&req_ready; wmode, addr, wmask and wdata pass through from the request.
- Writes produce no response. A write with wmask=0 is accepted and leaves the array unchanged.
- Read credit: req_ready = (state==RUN) && (req_write || fifo_count + inflight < RESP_DEPTH).
  - inflight is a 1-bit flag: a read was issued last cycle.
  - req_ready does not depend combinationally on resp_ready.
- Capture: in the cycle after a read issues, sram_rdata is pushed into the response FIFO. Pushes are unconditional; credit accounting guarantees space.
- Response FIFO: RESP_DEPTH entries, in order. Simultaneous push and pop is legal, with count unchanged.
- Ordering: the SRAM serialises accesses. A read issued the cycle after a write to the same address returns the new data.
- Reset mid-operation: the FIFO is flushed, inflight is cleared, pending responses are dropped, and the clear sweep restarts.
- Reset values: req_ready=0, resp_valid=0, init_done=0, sram_en=0, sram_wmode=0, sram_addr=0, sram_wmask=0, sram_wdata=0.

## Timing
- init_done rises 512 cycles after the first cycle with reset=0 (CLEAR_ON_RESET=1), or 1 cycle after (CLEAR_ON_RESET=0).
- Write accepted at cycle t: the array is updated at the end of t.
- Read accepted at cycle t: sram_rdata is valid in t+1 and captured at the end of t+1. resp_valid is high from t+2 (minimum latency 2).
- Throughput: 1 read/cycle is sustained while resp_ready=1. With resp_ready=0, at most RESP_DEPTH reads are accepted.
- resp_data holds stable while resp_valid && !resp_ready.

## Structure
- Package array_27_pkg holds:
  - constants DEPTH, ADDR_W, DATA_W, MASK_SEG, SEG_W=21
  - state enum {INIT, RUN}
- Sub-module array_27_resp_fifo holds the response buffer: parameterised depth, count output, flow-through disabled.
- The top level holds the FSM, init counter, inflight flag, credit logic and port muxing.

## Test plan
- Reset release, then read addresses 0, 255 and 511 after init_done → all three return 0. init_done rises exactly 512 cycles after reset release.
- Write addr 5 with data all ones and wmask=10'b0000000001, then read addr 5 → resp_data[20:0]=all ones and every other bit 0.
- Write addr 7 = D at cycle t, then read addr 7 at t+1 → resp_data=D, resp_valid at t+3.
- Hold resp_ready=0 and stream 6 reads → exactly 3 accepted and req_ready low afterwards. Then set resp_ready=1 → the responses drain in order and streaming resumes at 1/cycle.
- 100 back-to-back reads with resp_ready=1 → req_ready never drops and the responses match a reference model in order.
- Assert reset with 2 responses buffered and 1 read in flight → resp_valid=0 the next cycle and the clear sweep restarts. A subsequent read of the previously written address returns 0.

Source files
------------

// File: rtl/array_27_pkg.sv
// Shared constants and types for the array_27 request-side controller.
package array_27_pkg;
  localparam int DEPTH    = 512;
  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 210;
  localparam int MASK_SEG = 10;
  localparam int SEG_W    = DATA_W / MASK_SEG;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // One RW0 port command, as presented to the macro in a given cycle.
  typedef struct packed {
    logic                en;
    logic                wmode;
    logic [ADDR_W-1:0]   addr;
    logic [MASK_SEG-1:0] wmask;
    logic [DATA_W-1:0]   wdata;
  } sram_cmd_t;
endpackage

// File: rtl/array_27_rw_ctrl_if.sv
// Request, response and RW0 macro signals of the array_27 controller.
interface array_27_rw_ctrl_if;
  import array_27_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [MASK_SEG-1:0] req_wmask;
  logic [DATA_W-1:0]   req_wdata;

  logic                resp_valid;
  logic                resp_ready;
  logic [DATA_W-1:0]   resp_data;

  logic                init_done;

  logic                sram_en;
  logic                sram_wmode;
  logic [ADDR_W-1:0]   sram_addr;
  logic [MASK_SEG-1:0] sram_wmask;
  logic [DATA_W-1:0]   sram_wdata;
  logic [DATA_W-1:0]   sram_rdata;

  // master: the pipeline plus the macro around the controller
  modport master (
    output req_valid, req_write, req_addr, req_wmask, req_wdata,
    output resp_ready, sram_rdata,
    input  req_ready, resp_valid, resp_data, init_done,
    input  sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata
  );

  // slave: the controller itself
  modport slave (
    input  req_valid, req_write, req_addr, req_wmask, req_wdata,
    input  resp_ready, sram_rdata,
    output req_ready, resp_valid, resp_data, init_done,
    output sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata
  );
endinterface

// File: rtl/array_27_resp_fifo.sv
// In-order response buffer; registered output, so a push is visible next cycle.
module array_27_resp_fifo #(
  parameter int  ENTRIES = 3,
  parameter int  WIDTH   = 8,
  localparam int CNT_W   = $clog2(ENTRIES + 1),
  localparam int PTR_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);
  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = wrap_inc(wr_q);
    if (do_pop) rd_d = wrap_inc(rd_q);
    case ({push_i, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is data-path only; occupancy is what reset clears.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/array_27_rw_ctrl.sv
// RW0 request controller for the 512x210 masked SRAM: clear sweep, request muxing,
// and credit-limited in-order read return.
module array_27_rw_ctrl
  import array_27_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int RESP_DEPTH     = 3
) (
  input logic               clock,
  input logic               reset,
  array_27_rw_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              inflight_q;

  sram_cmd_t         cmd;
  logic              ready;
  logic              credit_ok;
  logic              rd_issue;
  logic              fifo_valid;
  logic              resp_pop;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [DATA_W-1:0] fifo_data;

  // Every accepted read is either in flight or buffered; never exceed the buffer.
  assign credit_ok = (32'(fifo_cnt) + 32'(inflight_q)) < 32'(RESP_DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      if (!CLEAR_ON_RESET || (cnt_q == ADDR_W'(DEPTH - 1))) state_d = RUN;
      else                                                  cnt_d   = cnt_q + ADDR_W'(1);
    end
  end

  // Outputs are forced to their idle values while reset is held.
  always_comb begin
    cmd   = '0;
    ready = 1'b0;
    if (!reset) begin
      if (state_q == RUN) begin
        ready     = bus.req_write || credit_ok;
        cmd.en    = bus.req_valid && ready;
        cmd.wmode = bus.req_write;
        cmd.addr  = bus.req_addr;
        cmd.wmask = bus.req_wmask;
        cmd.wdata = bus.req_wdata;
      end else if (CLEAR_ON_RESET) begin
        cmd.en    = 1'b1;
        cmd.wmode = 1'b1;
        cmd.addr  = cnt_q;
        cmd.wmask = '1;
      end
    end
  end

  assign rd_issue = cmd.en && !cmd.wmode;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= rd_issue;
    end
  end

  // Macro output is valid the cycle after a read issues; capture it unconditionally.
  array_27_resp_fifo #(
    .ENTRIES (RESP_DEPTH),
    .WIDTH   (DATA_W)
  ) u_resp_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (inflight_q),
    .data_i  (bus.sram_rdata),
    .pop_i   (resp_pop),
    .valid_o (fifo_valid),
    .data_o  (fifo_data),
    .count_o (fifo_cnt)
  );

  assign resp_pop       = bus.resp_valid && bus.resp_ready;

  assign bus.req_ready  = ready;
  assign bus.resp_valid = fifo_valid && !reset;
  assign bus.resp_data  = fifo_data;
  assign bus.init_done  = (state_q == RUN) && !reset;

  assign bus.sram_en    = cmd.en;
  assign bus.sram_wmode = cmd.wmode;
  assign bus.sram_addr  = cmd.addr;
  assign bus.sram_wmask = cmd.wmask;
  assign bus.sram_wdata = cmd.wdata;
endmodule

// File: tb/tb_array_27_rw_ctrl.sv
// Bench for array_27_rw_ctrl: macro model, array/queue reference model, vector table.
module tb_array_27_rw_ctrl;
  import array_27_pkg::*;

  localparam int RESP_DEPTH = 3;

  typedef struct {
    logic [ADDR_W-1:0]   addr;
    logic [MASK_SEG-1:0] mask;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  array_27_rw_ctrl_if bus();

  array_27_rw_ctrl #(
    .CLEAR_ON_RESET (1'b1),
    .RESP_DEPTH     (RESP_DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [DATA_W-1:0] masked(input logic [DATA_W-1:0] old_w,
                                               input logic [DATA_W-1:0] new_w,
                                               input logic [MASK_SEG-1:0] m);
    logic [DATA_W-1:0] r = old_w;
    for (int s = 0; s < MASK_SEG; s++)
      if (m[s]) r[s*SEG_W +: SEG_W] = new_w[s*SEG_W +: SEG_W];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rand_word();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom;
    return t[DATA_W-1:0];
  endfunction

  // Macro model: masked write, registered 1-cycle read.
  logic [DATA_W-1:0] sram_mem [DEPTH];
  logic [DATA_W-1:0] sram_rd_q;
  always @(posedge clock) begin
    if (bus.sram_en) begin
      if (bus.sram_wmode)
        sram_mem[bus.sram_addr] <= masked(sram_mem[bus.sram_addr], bus.sram_wdata, bus.sram_wmask);
      else
        sram_rd_q <= sram_mem[bus.sram_addr];
    end
  end
  assign bus.sram_rdata = sram_rd_q;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];

  logic acc, got_resp;
  logic [DATA_W-1:0] last_resp;
  logic s_rdy, s_rv, s_done, s_en, s_wm;
  logic [ADDR_W-1:0] s_addr;
  logic [MASK_SEG-1:0] s_mask;
  logic [DATA_W-1:0] s_wdata, s_rdata;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: observe mid-cycle, update the reference model, return just after the edge.
  task automatic tick();
    @(negedge clock);
    s_rdy   = bus.req_ready;
    s_rv    = bus.resp_valid;
    s_rdata = bus.resp_data;
    s_done  = bus.init_done;
    s_en    = bus.sram_en;
    s_wm    = bus.sram_wmode;
    s_addr  = bus.sram_addr;
    s_mask  = bus.sram_wmask;
    s_wdata = bus.sram_wdata;
    acc      = bus.req_valid && bus.req_ready;
    got_resp = bus.resp_valid && bus.resp_ready;
    if (reset) begin
      exp_q.delete();
      foreach (ref_mem[i]) ref_mem[i] = '0;
    end else begin
      if (acc) begin
        if (bus.req_write) begin
          ref_mem[bus.req_addr] = masked(ref_mem[bus.req_addr], bus.req_wdata, bus.req_wmask);
        end else begin
          exp_q.push_back(ref_mem[bus.req_addr]);
          chk_i("read_credit", (exp_q.size() > RESP_DEPTH) ? 1 : 0, 0);
        end
      end
      if (got_resp) begin
        last_resp = bus.resp_data;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_order: got unexpected response %h, none outstanding", bus.resp_data);
        end else begin
          chk("resp_data", bus.resp_data, exp_q.pop_front());
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_req(input string name, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [MASK_SEG-1:0] m, input logic [DATA_W-1:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wmask = m;
    bus.req_wdata = d;
    do begin tick(); n++; end while (!acc && n < 50);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL %s: request not accepted within %0d cycles", name, n);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    int n = 0;
    do begin tick(); n++; end while (!got_resp && n < 20);
    if (!got_resp) begin
      checks++;
      errors++;
      $display("FAIL %s: no response within %0d cycles", name, n);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
    chk_i(name, exp_q.size(), 0);
  endtask

  // Releases reset and checks the sweep start and init_done latency.
  task automatic release_and_check(input string name);
    int n = 0;
    reset = 1'b0;
    tick();
    chk_i({name, "_rv"},    int'(s_rv), 0);
    chk_i({name, "_rdy"},   int'(s_rdy), 0);
    chk_i({name, "_en"},    int'(s_en), 1);
    chk_i({name, "_wmode"}, int'(s_wm), 1);
    chk_i({name, "_addr"},  int'(s_addr), 0);
    chk_i({name, "_wmask"}, int'(s_mask), 1023);
    chk({name, "_wdata"}, s_wdata, '0);
    while (!s_done && n < 600) begin tick(); n++; end
    chk_i({name, "_init_latency"}, n, 512);
  endtask

  vec_t vecs[7];
  logic [DATA_W-1:0] ones;
  logic [DATA_W-1:0] d7, held;
  int rd0[3];
  int n, accepts;
  logic have_held;

  initial begin
    ones = '1;
    rd0  = '{0, 255, 511};
    vecs[0] = '{addr: 9'd5,   mask: 10'b0000000001, wdata: ones, exp: {189'b0, 21'h1fffff}};
    vecs[1] = '{addr: 9'd5,   mask: 10'b0000000000, wdata: ones, exp: {189'b0, 21'h1fffff}};
    vecs[2] = '{addr: 9'd9,   mask: 10'b1000000000, wdata: ones, exp: {21'h1fffff, 189'b0}};
    vecs[3] = '{addr: 9'd9,   mask: 10'b1000000000, wdata: '0,   exp: '0};
    vecs[4] = '{addr: 9'd300, mask: 10'b1111111111, wdata: ones, exp: ones};
    vecs[5] = '{addr: 9'd300, mask: 10'b0101010101, wdata: '0,   exp: {5{21'h1fffff, 21'h0}}};
    vecs[6] = '{addr: 9'd300, mask: 10'b0000110000, wdata: {10{21'h0aaaaa}},
                exp: {21'h1fffff, 21'h0, 21'h1fffff, 21'h0, 21'h0aaaaa, 21'h0aaaaa,
                      21'h1fffff, 21'h0, 21'h1fffff, 21'h0}};

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wmask  = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk_i("rst_req_ready",  int'(s_rdy), 0);
    chk_i("rst_resp_valid", int'(s_rv), 0);
    chk_i("rst_init_done",  int'(s_done), 0);
    chk_i("rst_sram_en",    int'(s_en), 0);
    chk_i("rst_sram_wmode", int'(s_wm), 0);
    chk_i("rst_sram_addr",  int'(s_addr), 0);
    chk_i("rst_sram_wmask", int'(s_mask), 0);
    chk("rst_sram_wdata", s_wdata, '0);
    release_and_check("init");

    // Array cleared by the sweep
    foreach (rd0[i]) begin
      do_req("clr_rd", 1'b0, ADDR_W'(rd0[i]), '0, '0);
      wait_resp("clr_rd");
      chk("clr_rd_data", last_resp, '0);
    end

    // Masked write vectors
    for (int i = 0; i < 7; i++) begin
      do_req("vec_wr", 1'b1, vecs[i].addr, vecs[i].mask, vecs[i].wdata);
      do_req("vec_rd", 1'b0, vecs[i].addr, '0, '0);
      wait_resp("vec_rd");
      chk($sformatf("vec%0d", i), last_resp, vecs[i].exp);
    end

    // Read right after a write to the same address sees the new data
    d7 = rand_word() | 210'd1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 9'd7;
    bus.req_wmask = '1;   bus.req_wdata = d7;
    tick();
    chk_i("raw_wr_acc", int'(acc), 1);
    bus.req_write = 1'b0;
    tick();
    chk_i("raw_rd_acc", int'(acc), 1);
    bus.req_valid = 1'b0;
    tick();
    chk_i("raw_rv_t2", int'(s_rv), 0);
    tick();
    chk_i("raw_rv_t3", int'(s_rv), 1);
    chk("raw_data", s_rdata, d7);

    // Backpressure: only RESP_DEPTH reads accepted, held data stable
    for (int a = 20; a < 26; a++) do_req("bp_wr", 1'b1, ADDR_W'(a), '1, rand_word());
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1; bus.req_write = 1'b0; bus.req_addr = 9'd20;
    accepts = 0;
    have_held = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (acc) begin accepts++; bus.req_addr = bus.req_addr + 9'd1; end
      if (s_rv && have_held) chk("bp_hold", s_rdata, held);
      if (s_rv && !have_held) begin held = s_rdata; have_held = 1'b1; end
    end
    chk_i("bp_accepts", accepts, 3);
    chk_i("bp_ready_low", int'(s_rdy), 0);
    bus.resp_ready = 1'b1;
    n = 0;
    while (accepts < 6 && n < 20) begin
      tick(); n++;
      if (acc) begin accepts++; bus.req_addr = bus.req_addr + 9'd1; end
    end
    chk_i("bp_resume_cycles", n, 4);
    bus.req_valid = 1'b0;
    drain("bp_drain");

    // 100 back-to-back reads over randomly written data
    for (int i = 0; i < 40; i++)
      do_req("rnd_wr", 1'b1, ADDR_W'($urandom_range(0, 63)), MASK_SEG'($urandom), rand_word());
    bus.req_valid = 1'b1; bus.req_write = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.req_addr = ADDR_W'($urandom_range(0, 63));
      tick();
      chk_i("b2b_ready", int'(acc), 1);
    end
    bus.req_valid = 1'b0;
    drain("b2b_drain");

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      bus.req_valid  = 1'($urandom_range(0, 1));
      bus.req_write  = ($urandom_range(0, 2) == 0);
      bus.req_addr   = ADDR_W'($urandom_range(0, 31));
      bus.req_wmask  = MASK_SEG'($urandom);
      bus.req_wdata  = rand_word();
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    drain("rnd_drain");

    // Reset with two responses buffered and one read in flight
    do_req("mr_wr", 1'b1, 9'd40, '1, rand_word() | 210'd1);
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 9'd40;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_i("mr_rd_acc", int'(acc), 1);
    end
    bus.req_valid = 1'b0;
    reset = 1'b1;
    tick();
    bus.resp_ready = 1'b1;
    release_and_check("mr");
    chk_i("mr_no_stale", exp_q.size(), 0);
    do_req("mr_rd", 1'b0, 9'd40, '0, '0);
    wait_resp("mr_rd");
    chk("mr_rd_data", last_resp, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
